// File: rtl/div_seq_ctrl.sv
// Sequencing controller around a 32-bit unsigned multicycle divider core.
// It implements RISC-V DIV/DIVU/REM/REMU and resolves the special cases locally.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             kill,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_DONE, S_DRAIN
  } state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = '1;

  state_e           state_q;
  logic             rem_q, sa_q, sb_q, seen_busy_q, resp_valid_q;
  logic [WIDTH-1:0] resp_data_q, div_a_q, div_b_q;

  logic             is_signed, sa_d, sb_d, ovf_d, small_d;
  logic [WIDTH-1:0] mag_a_d, mag_b_d, q_fix_d, r_fix_d;

  // Operand decode: 0x80000000 negates to itself and reads as an unsigned magnitude.
  always_comb begin
    is_signed = ~req_op[0];
    sa_d      = is_signed & req_a[WIDTH-1];
    sb_d      = is_signed & req_b[WIDTH-1];
    mag_a_d   = sa_d ? -req_a : req_a;
    mag_b_d   = sb_d ? -req_b : req_b;
    ovf_d     = is_signed && (req_a == MIN_NEG) && (req_b == ALL_ONE);
    small_d   = mag_a_d < mag_b_d;
    q_fix_d   = (sa_q ^ sb_q) ? -div_q : div_q;
    r_fix_d   = sa_q ? -div_r : div_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= 1'b0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      seen_busy_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !kill) begin
            rem_q <= req_op[1];
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            if (req_b == '0) begin
              resp_data_q  <= req_op[1] ? req_a : ALL_ONE;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else if (ovf_d) begin
              resp_data_q  <= req_op[1] ? '0 : MIN_NEG;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else if (small_d) begin
              resp_data_q  <= req_op[1] ? req_a : '0;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              div_a_q <= mag_a_d;
              div_b_q <= mag_b_d;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state_q <= kill ? S_IDLE : S_ARM;
        S_ARM: begin
          if (kill) begin
            seen_busy_q <= div_busy;
            state_q     <= S_DRAIN;
          end else if (div_busy) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The core has already been seen busy here, so draining only waits for it to fall.
          if (kill) begin
            seen_busy_q <= 1'b1;
            state_q     <= S_DRAIN;
          end else if (!div_busy) begin
            resp_data_q  <= rem_q ? r_fix_d : q_fix_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (kill || resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (seen_busy_q && !div_busy) begin
            seen_busy_q <= 1'b0;
            state_q     <= S_IDLE;
          end else if (div_busy) begin
            seen_busy_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !kill;
  assign div_start  = (state_q == S_ISSUE) && !kill;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl with a behavioural multicycle divider core.
module tb_div_seq_ctrl;
  localparam int W      = 32;
  localparam int CORE_N = 33;

  logic         clk = 1'b0;
  logic         rst, req_valid, req_ready, kill, resp_valid, resp_ready, busy;
  logic         div_start, div_busy;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b, resp_data, div_a, div_b, div_q, div_r;

  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  int           starts   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  // Core model: busy rises the cycle after start and stays up CORE_N cycles.
  logic [W-1:0] ca, cb, cq, cr;
  logic         cbusy;
  int           ccnt;
  always @(posedge clk) begin
    if (rst) begin
      cbusy <= 1'b0; ccnt <= 0; cq <= '0; cr <= '0; ca <= '0; cb <= 1;
    end else if (div_start) begin
      ca <= div_a; cb <= div_b; cbusy <= 1'b1; ccnt <= CORE_N;
    end else if (cbusy) begin
      if (ccnt == 1) begin
        cbusy <= 1'b0; cq <= ca / cb; cr <= ca % cb;
      end
      ccnt <= ccnt - 1;
    end
  end
  assign div_busy = cbusy;
  assign div_q    = cq;
  assign div_r    = cr;

  always @(posedge clk) if (!rst && div_start) starts++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] q, r;
    if (b == '0) begin q = '1; r = a; end
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = '0; end
    else if (op[0]) begin q = a / b; r = a % b; end
    else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    return op[1] ? r : q;
  endfunction

  // kind: 0 special case, 1 core path, 2 unconstrained; hold = cycles of backpressure
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input int kind, input int hold);
    int n, lat, s0;
    logic [W-1:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin chk("accept_timeout", 1, 0); req_valid = 1'b0; return; end
    s0 = starts;
    exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    if (!resp_valid) begin chk("resp_timeout", 1, 0); return; end
    chk("data", resp_data, e);
    if (kind == 0) begin
      chk("lat_special", lat, 1);
      chk("no_start", starts - s0, 0);
    end else if (kind == 1) begin
      chk("lat_le40", (lat <= 40), 1);
      chk("one_start", starts - s0, 1);
    end
    repeat (hold) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_data, e);
      chk("hold_rdy", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("rv_drop", resp_valid, 0);
    chk("idle_rdy", req_ready, 1);
  endtask

  initial begin
    int n;
    logic bad;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    kill = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);

    send(2'b01, 100, 7, 14, 1, 0);
    send(2'b11, 100, 7, 2, 1, 0);
    send(2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 1, 0);
    chk("div_a_mag", div_a, 7);
    chk("div_b_mag", div_b, 2);
    send(2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 1, 0);

    send(2'b00, 5, 0, 32'hFFFF_FFFF, 0, 0);
    send(2'b10, 5, 0, 5, 0, 0);
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    send(2'b01, 3, 10, 0, 0, 0);
    send(2'b11, 3, 10, 3, 0, 0);
    send(2'b00, 32'hFFFF_FFFD, 10, 0, 0, 0);
    send(2'b10, 32'hFFFF_FFFD, 10, 32'hFFFF_FFFD, 0, 0);
    chk("div_a_kept", div_a, 7);

    // Kill mid-division: no response, controller stays closed until the core idles.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 100; req_b = 7;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("kill_in_wait", div_busy, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    bad = 1'b0; n = 0;
    while (div_busy && n < 60) begin
      if (resp_valid || req_ready) bad = 1'b1;
      @(negedge clk); n++;
    end
    chk("kill_busy_fall", div_busy, 0);
    chk("kill_closed", bad, 0);
    chk("kill_drain_rdy", req_ready, 0);
    @(negedge clk);
    chk("kill_idle_rdy", req_ready, 1);
    chk("kill_no_resp", resp_valid, 0);
    send(2'b01, 100, 7, 14, 1, 0);

    send(2'b01, 1000, 9, 111, 1, 5);
    send(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 1, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 28);
      send(rop, ra, rb, ref_res(rop, ra, rb), 2, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
